mfpga_xfer_ctrl: RTL and testbench
==================================

# mfpga_xfer_ctrl

Burst transfer controller for the master-FPGA inter-board link. It arbitrates between a write requester and a read requester and sequences each burst over the shared 32-bit bidirectional bus (`data_out` / `data_ov`) using the `m_wr_req` / `m_rd_req` / `s_ready` handshake. It owns the bus output enable and inserts a turnaround cycle between bursts. It moves write data from a TX FIFO and pushes read data into the RX buffer FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: bus and FIFO data width.
- `LEN_W`, default 8: burst-length field width; a burst carries `len+1` beats, i.e. 1..2^LEN_W beats.
- `TIMEOUT`, default 1023: maximum number of consecutive stall cycles before a burst is aborted.

Ports:
- `clk`  in  1: single clock; `m_clk` is driven from it externally.
- `reset`  in  1: asynchronous, active-low reset.
- `wr_start`  in  1: write burst request pulse.
- `wr_len`  in  LEN_W: write burst length minus 1; sampled with `wr_start`.
- `rd_start`  in  1: read burst request pulse.
- `rd_len`  in  LEN_W: read burst length minus 1; sampled with `rd_start`.
- `tx_data`  in  DATA_WIDTH: TX FIFO head word (first-word-fall-through).
- `tx_empty`  in  1: TX FIFO empty.
- `tx_pop`  out  1: TX FIFO pop.
- `rx_full`  in  1: RX FIFO full.
- `rx_push`  out  1: RX FIFO push.
- `rx_data`  out  DATA_WIDTH: RX FIFO write data.
- `s_ready`  in  1: slave ready.
- `m_wr_req`  out  1: write request / write-phase indicator to the slave.
- `m_rd_req`  out  1: read request and read flow control to the slave.
- `bus_oe`  out  1: tri-state enable for `data_out` and `data_ov`.
- `bus_dout`  out  DATA_WIDTH: outgoing bus data.
- `bus_ov_out`  out  1: outgoing bus valid.
- `bus_din`  in  DATA_WIDTH: incoming bus data.
- `bus_ov_in`  in  1: incoming bus valid.
- `busy`  out  1: controller not in IDLE, or a request is pending.
- `done`  out  1: one-cycle pulse on normal burst completion.
- `err`  out  1: one-cycle pulse on timeout abort or RX overflow.

## Operation
States: IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA, TURN.

Request capture:
- A `wr_start` or `rd_start` pulse sets `wr_pend` / `rd_pend` and latches the length.
- A start pulse whose pending flag is already set is ignored.
- A pending flag clears on grant.

Arbitration (IDLE only):
- IDLE considers pending flags and same-cycle start pulses.
- Single requester: grant it.
- Both requesting: round-robin. The requester not granted last wins. After reset the last grant is "read", so write wins the first tie.

Write burst:
- WR_REQ: `m_wr_req`=1, `bus_oe`=1, `bus_ov_out`=0. When `s_ready`=1, go to WR_DATA.
- WR_DATA: `m_wr_req`=1, `bus_oe`=1, `bus_dout`=`tx_data`, `bus_ov_out`=!`tx_empty`.
- Beat = `bus_ov_out` & `s_ready`; `tx_pop` = beat. The counter loads `len` and decrements per beat.
- A beat with counter = 0 goes to TURN and pulses `done`.

Read burst:
- RD_REQ: `m_rd_req`=1, `bus_oe`=0. When `s_ready`=1, go to RD_DATA.
- RD_DATA: `m_rd_req` = !`rx_full`. `rx_data` = `bus_din`.
- Beat = `bus_ov_in` & `m_rd_req`; `rx_push` = beat.
- `bus_ov_in`=1 while `m_rd_req`=0 is an overflow: the word is dropped, `err` pulses, and the beat is not counted.
- A last beat goes to TURN and pulses `done`.

TURN:
- One cycle with `bus_oe`=0 and all requests low, then IDLE.
- Back-to-back bursts are therefore separated by at least one TURN cycle plus one IDLE cycle.

Timeout:
- The stall counter counts cycles in WR_REQ, WR_DATA, RD_REQ and RD_DATA with no beat and no REQ→DATA transition. It clears on any beat or state change.
- Reaching `TIMEOUT` aborts the burst: `err` pulses, the state goes to TURN, and no `done` is issued.

`busy` = (state≠IDLE) | `wr_pend` | `rd_pend`.

## Timing
- Reset (`reset`=0, asynchronous):
  - State is IDLE; pending flags, counters and last-grant are cleared.
  - All outputs are 0, including `bus_oe`=0 (bus released).
  - Reset mid-burst aborts immediately; no `done` or `err` is issued.
- Start pulse in cycle N with controller IDLE: state is WR_REQ/RD_REQ in cycle N+1, so `m_*_req` is high in N+1.
- `s_ready` is sampled in REQ; the first data beat can occur in the cycle after `s_ready` is seen.
- `tx_pop`, `bus_ov_out`, `m_rd_req` (in RD_DATA) and `rx_push` are combinational from the current state and inputs. All other outputs are registered.
- `done` and `err` are asserted in the cycle in which the state is TURN.
- Minimum length-L write: 1 REQ cycle + (L+1) beats + 1 TURN cycle.

## Test plan
- Write, `wr_len`=3, TX FIFO holds 4 words, `s_ready` held 1 → `m_wr_req` high 5 cycles, exactly 4 `tx_pop`, `bus_ov_out` high 4 cycles, `done` once, `bus_oe` low in TURN.
- Read, `rd_len`=7, slave returns 8 words, `rx_full` toggles high for 2 cycles mid-burst → `m_rd_req` drops for those 2 cycles, 8 `rx_push` with data in order, `done`, no `err`.
- `wr_start` and `rd_start` in the same cycle from reset → write granted first, read follows after TURN+IDLE; a second simultaneous pair → read first.
- Write burst with `s_ready` stuck 0, `TIMEOUT`=15 → `err` pulse 16 cycles after entering WR_REQ, no `done`, IDLE two cycles later.
- `bus_ov_in`=1 while `rx_full`=1 → `err` pulse, no `rx_push`, beat counter unchanged.
- `reset` asserted during RD_DATA beat 3 of 8 → all outputs 0 immediately; after release, `busy`=0 and a new write completes normally.

Source files
------------

// File: rtl/mfpga_xfer_ctrl.sv
// Burst transfer controller for the master-FPGA inter-board link: arbitrates
// write/read requesters, sequences bursts on the shared bus, inserts turnaround.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | bus released, arbitrating pending/new requests
// S_WR_REQ  | write requested, driving bus, waiting for s_ready
// S_WR_DATA | write beats from TX FIFO
// S_RD_REQ  | read requested, bus released, waiting for s_ready
// S_RD_DATA | read beats into RX FIFO, m_rd_req as flow control
// S_TURN    | one turnaround cycle, done/err visible here
module mfpga_xfer_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_start,
    input  logic [LEN_W-1:0]      wr_len,
    input  logic                  rd_start,
    input  logic [LEN_W-1:0]      rd_len,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_empty,
    output logic                  tx_pop,
    input  logic                  rx_full,
    output logic                  rx_push,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  s_ready,
    output logic                  m_wr_req,
    output logic                  m_rd_req,
    output logic                  bus_oe,
    output logic [DATA_WIDTH-1:0] bus_dout,
    output logic                  bus_ov_out,
    input  logic [DATA_WIDTH-1:0] bus_din,
    input  logic                  bus_ov_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] TMO = SW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_DATA,
        S_RD_REQ,
        S_RD_DATA,
        S_TURN
    } state_t;

    state_t           state_q, state_d;
    logic             wr_pend_q, wr_pend_d;
    logic             rd_pend_q, rd_pend_d;
    logic [LEN_W-1:0] wr_len_q, wr_len_d;
    logic [LEN_W-1:0] rd_len_q, rd_len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic             last_wr_q, last_wr_d;
    logic             m_wr_req_q, m_wr_req_d;
    logic             rd_req_q, rd_req_d;
    logic             bus_oe_q, bus_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic wr_data_st, rd_data_st;
    logic wr_beat, rd_beat, overflow;
    logic wr_req_any, rd_req_any;
    logic grant_wr, grant_rd;
    logic stalled;

    assign wr_data_st = (state_q == S_WR_DATA);
    assign rd_data_st = (state_q == S_RD_DATA);

    // Data-phase handshakes stay combinational so each beat lines up with FIFO data.
    assign bus_ov_out = wr_data_st & ~tx_empty;
    assign wr_beat    = bus_ov_out & s_ready;
    assign tx_pop     = wr_beat;
    assign bus_dout   = wr_data_st ? tx_data : '0;

    assign m_rd_req   = rd_req_q | (rd_data_st & ~rx_full);
    assign rd_beat    = rd_data_st & bus_ov_in & ~rx_full;
    assign overflow   = rd_data_st & bus_ov_in & rx_full;
    assign rx_push    = rd_beat;
    assign rx_data    = rd_data_st ? bus_din : '0;

    assign m_wr_req = m_wr_req_q;
    assign bus_oe   = bus_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    assign wr_req_any = wr_pend_q | wr_start;
    assign rd_req_any = rd_pend_q | rd_start;

    always_comb begin
        state_d   = state_q;
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        wr_len_d  = wr_len_q;
        rd_len_d  = rd_len_q;
        cnt_d     = cnt_q;
        stall_d   = '0;
        last_wr_d = last_wr_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        stalled   = 1'b0;

        grant_wr = wr_req_any & (~rd_req_any | ~last_wr_q);
        grant_rd = rd_req_any & ~grant_wr;

        if (wr_start && !wr_pend_q) begin
            wr_pend_d = 1'b1;
            wr_len_d  = wr_len;
        end
        if (rd_start && !rd_pend_q) begin
            rd_pend_d = 1'b1;
            rd_len_d  = rd_len;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_wr) begin
                    state_d   = S_WR_REQ;
                    wr_pend_d = 1'b0;
                    cnt_d     = wr_pend_q ? wr_len_q : wr_len;
                    last_wr_d = 1'b1;
                end else if (grant_rd) begin
                    state_d   = S_RD_REQ;
                    rd_pend_d = 1'b0;
                    cnt_d     = rd_pend_q ? rd_len_q : rd_len;
                    last_wr_d = 1'b0;
                end
            end
            S_WR_REQ: begin
                if (s_ready) state_d = S_WR_DATA;
                else         stalled = 1'b1;
            end
            S_WR_DATA: begin
                if (wr_beat) begin
                    if (cnt_q == '0) begin
                        state_d = S_TURN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else begin
                    stalled = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (s_ready) state_d = S_RD_DATA;
                else         stalled = 1'b1;
            end
            S_RD_DATA: begin
                // A word arriving while we hold off is dropped and not counted.
                if (overflow) err_d = 1'b1;
                if (rd_beat) begin
                    if (cnt_q == '0) begin
                        state_d = S_TURN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else begin
                    stalled = 1'b1;
                end
            end
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (stalled) begin
            if (stall_q == TMO) begin
                state_d = S_TURN;
                err_d   = 1'b1;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end

        m_wr_req_d = (state_d == S_WR_REQ) || (state_d == S_WR_DATA);
        bus_oe_d   = m_wr_req_d;
        rd_req_d   = (state_d == S_RD_REQ);
        busy_d     = (state_d != S_IDLE) | wr_pend_d | rd_pend_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            wr_len_q   <= '0;
            rd_len_q   <= '0;
            cnt_q      <= '0;
            stall_q    <= '0;
            last_wr_q  <= 1'b0;
            m_wr_req_q <= 1'b0;
            rd_req_q   <= 1'b0;
            bus_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            wr_len_q   <= wr_len_d;
            rd_len_q   <= rd_len_d;
            cnt_q      <= cnt_d;
            stall_q    <= stall_d;
            last_wr_q  <= last_wr_d;
            m_wr_req_q <= m_wr_req_d;
            rd_req_q   <= rd_req_d;
            bus_oe_q   <= bus_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mfpga_xfer_ctrl.sv
// Directed bench for mfpga_xfer_ctrl: TX FIFO and read slave models, negedge monitor.
module tb_mfpga_xfer_ctrl;

    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_start, rd_start;
    logic [LW-1:0] wr_len, rd_len;
    logic [DW-1:0] tx_data;
    logic          tx_empty, tx_pop;
    logic          rx_full, rx_push;
    logic [DW-1:0] rx_data;
    logic          s_ready;
    logic          m_wr_req, m_rd_req, bus_oe;
    logic [DW-1:0] bus_dout;
    logic          bus_ov_out;
    logic [DW-1:0] bus_din;
    logic          bus_ov_in;
    logic          busy, done, err;

    always #5 clk = ~clk;

    mfpga_xfer_ctrl #(.DATA_WIDTH(DW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .wr_start(wr_start), .wr_len(wr_len), .rd_start(rd_start), .rd_len(rd_len),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_pop(tx_pop),
        .rx_full(rx_full), .rx_push(rx_push), .rx_data(rx_data),
        .s_ready(s_ready), .m_wr_req(m_wr_req), .m_rd_req(m_rd_req),
        .bus_oe(bus_oe), .bus_dout(bus_dout), .bus_ov_out(bus_ov_out),
        .bus_din(bus_din), .bus_ov_in(bus_ov_in),
        .busy(busy), .done(done), .err(err)
    );

    // TX FIFO (first-word-fall-through) and read slave, both written by tasks only
    logic [DW-1:0] tx_mem [0:7];
    logic [DW-1:0] rd_mem [0:7];
    logic [3:0]    tx_cnt = 4'd0;
    logic [3:0]    rk_max = 4'd0;
    logic          slave_en = 1'b0;
    logic          force_ov = 1'b0;
    logic          fifo_clr = 1'b0;
    logic [3:0]    tx_ptr = 4'd0;
    logic [3:0]    rk = 4'd0;

    assign tx_data   = tx_mem[tx_ptr[2:0]];
    assign tx_empty  = (tx_ptr >= tx_cnt);
    assign bus_din   = rd_mem[rk[2:0]];
    assign bus_ov_in = (slave_en & (rk < rk_max) & m_rd_req) | force_ov;

    // monitor state, written only by the negedge block
    int   cyc = 0;
    int   n_wrreq = 0, n_rdreq = 0, n_pop = 0, n_ov = 0, n_push = 0;
    int   n_done = 0, n_err = 0, n_oe_turn = 0;
    int   done_cyc = 0, err_cyc = 0, wr_rise_cyc = 0;
    logic prev_wr = 1'b0, prev_rd = 1'b0;
    logic pop_seen = 1'b0, push_seen = 1'b0;
    logic [DW-1:0] rxq [$];
    logic [DW-1:0] wq [$];
    byte           gq [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_wr_req) n_wrreq = n_wrreq + 1;
        if (m_rd_req) n_rdreq = n_rdreq + 1;
        if (tx_pop) n_pop = n_pop + 1;
        if (bus_ov_out) n_ov = n_ov + 1;
        if (done) begin
            n_done = n_done + 1;
            done_cyc = cyc;
            if (bus_oe) n_oe_turn = n_oe_turn + 1;
        end
        if (err) begin
            n_err = n_err + 1;
            err_cyc = cyc;
        end
        if (rx_push) begin
            n_push = n_push + 1;
            rxq.push_back(rx_data);
        end
        if (bus_ov_out && s_ready) wq.push_back(bus_dout);
        if (m_wr_req && !prev_wr) begin
            gq.push_back(8'h57);
            wr_rise_cyc = cyc;
        end
        if (m_rd_req && !prev_rd) gq.push_back(8'h52);
        prev_wr   = m_wr_req;
        prev_rd   = m_rd_req;
        pop_seen  = tx_pop;
        push_seen = rx_push;
    end

    always @(posedge clk) begin
        if (fifo_clr) begin
            tx_ptr <= 4'd0;
            rk     <= 4'd0;
        end else begin
            if (pop_seen)  tx_ptr <= tx_ptr + 4'd1;
            if (push_seen) rk     <= rk + 4'd1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_models();
        fifo_clr = 1'b1;
        tick(1);
        fifo_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if ({m_wr_req, m_rd_req, bus_oe, tx_pop, rx_push, bus_ov_out, busy, done, err} !== 9'b0)
            $display("FAIL reset_ctrl: got %b expected 000000000",
                     {m_wr_req, m_rd_req, bus_oe, tx_pop, rx_push, bus_ov_out, busy, done, err});
        else n_pass++;
        n_checks++;
        if ({bus_dout, rx_data} !== '0)
            $display("FAIL reset_data: got %h/%h expected 0/0", bus_dout, rx_data);
        else n_pass++;
        clr_models();
        tick(1);
        reset = 1'b1;
        tick(1);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_write();
        int b_wr, b_pop, b_ov, b_done, b_err, b_oe, wb;
        for (int i = 0; i < 4; i++) tx_mem[i] = 32'hA0A0_0000 + 32'(i);
        tx_cnt = 4'd4;
        clr_models();
        b_wr = n_wrreq; b_pop = n_pop; b_ov = n_ov; b_done = n_done; b_err = n_err;
        b_oe = n_oe_turn; wb = wq.size();
        s_ready = 1'b1;
        wr_len = 8'd3;
        wr_start = 1'b1;
        tick(1);
        wr_start = 1'b0;
        #1;
        n_checks++;
        if ({m_wr_req, bus_oe, bus_ov_out} !== 3'b110)
            $display("FAIL wr_req_phase: got %b expected 110", {m_wr_req, bus_oe, bus_ov_out});
        else n_pass++;
        tick(8);
        n_checks++;
        if (n_wrreq - b_wr !== 5) $display("FAIL wr_req_cycles: got %0d expected 5", n_wrreq - b_wr);
        else n_pass++;
        n_checks++;
        if (n_pop - b_pop !== 4) $display("FAIL wr_pops: got %0d expected 4", n_pop - b_pop);
        else n_pass++;
        n_checks++;
        if (n_ov - b_ov !== 4) $display("FAIL wr_ov_cycles: got %0d expected 4", n_ov - b_ov);
        else n_pass++;
        n_checks++;
        if (n_done - b_done !== 1 || n_err - b_err !== 0)
            $display("FAIL wr_done_err: got done %0d err %0d expected 1 0", n_done - b_done, n_err - b_err);
        else n_pass++;
        n_checks++;
        if (done_cyc - wr_rise_cyc !== 5)
            $display("FAIL wr_done_latency: got %0d expected 5", done_cyc - wr_rise_cyc);
        else n_pass++;
        n_checks++;
        if (n_oe_turn - b_oe !== 0) $display("FAIL wr_oe_in_turn: got %0d expected 0", n_oe_turn - b_oe);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wq.size() <= wb + i || wq[wb + i] !== 32'hA0A0_0000 + 32'(i))
                $display("FAIL wr_data[%0d]: got %h expected %h", i,
                         (wq.size() > wb + i) ? wq[wb + i] : 32'hx, 32'hA0A0_0000 + 32'(i));
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL wr_idle_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_read();
        int b_rd, b_push, b_done, b_err, rb;
        for (int i = 0; i < 8; i++) rd_mem[i] = 32'hB0B0_0000 + 32'(i);
        rk_max = 4'd8;
        clr_models();
        b_rd = n_rdreq; b_push = n_push; b_done = n_done; b_err = n_err; rb = rxq.size();
        slave_en = 1'b1;
        s_ready = 1'b1;
        rd_len = 8'd7;
        rd_start = 1'b1;
        tick(1);
        rd_start = 1'b0;
        #1;
        n_checks++;
        if ({m_rd_req, bus_oe} !== 2'b10)
            $display("FAIL rd_req_phase: got %b expected 10", {m_rd_req, bus_oe});
        else n_pass++;
        tick(4);
        rx_full = 1'b1;
        #1;
        n_checks++;
        if ({m_rd_req, rx_push} !== 2'b00)
            $display("FAIL rd_flow_ctrl: got %b expected 00", {m_rd_req, rx_push});
        else n_pass++;
        tick(2);
        rx_full = 1'b0;
        tick(7);
        slave_en = 1'b0;
        n_checks++;
        if (n_push - b_push !== 8) $display("FAIL rd_pushes: got %0d expected 8", n_push - b_push);
        else n_pass++;
        n_checks++;
        if (n_rdreq - b_rd !== 9) $display("FAIL rd_req_cycles: got %0d expected 9", n_rdreq - b_rd);
        else n_pass++;
        n_checks++;
        if (n_done - b_done !== 1 || n_err - b_err !== 0)
            $display("FAIL rd_done_err: got done %0d err %0d expected 1 0", n_done - b_done, n_err - b_err);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rxq.size() <= rb + i || rxq[rb + i] !== 32'hB0B0_0000 + 32'(i))
                $display("FAIL rd_data[%0d]: got %h expected %h", i,
                         (rxq.size() > rb + i) ? rxq[rb + i] : 32'hx, 32'hB0B0_0000 + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_arbitration();
        int gb, b_done;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tx_mem[i] = 32'hC0C0_0000 + 32'(i);
        for (int i = 0; i < 2; i++) rd_mem[i] = 32'hD0D0_0000 + 32'(i);
        tx_cnt = 4'd4;
        rk_max = 4'd2;
        clr_models();
        reset = 1'b1;
        tick(1);
        gb = gq.size(); b_done = n_done;
        slave_en = 1'b1;
        s_ready = 1'b1;
        wr_len = 8'd1;
        rd_len = 8'd1;
        wr_start = 1'b1;
        rd_start = 1'b1;
        tick(1);
        wr_start = 1'b0;
        rd_start = 1'b0;
        #1;
        n_checks++;
        if ({m_wr_req, m_rd_req} !== 2'b10)
            $display("FAIL arb_first_tie: got %b expected 10", {m_wr_req, m_rd_req});
        else n_pass++;
        tick(1);
        wr_len = 8'd0;
        wr_start = 1'b1;
        rd_start = 1'b1;
        tick(1);
        wr_start = 1'b0;
        rd_start = 1'b0;
        tick(2);
        n_checks++;
        if ({m_wr_req, m_rd_req, bus_oe, busy} !== 4'b0001)
            $display("FAIL arb_idle_gap: got %b expected 0001", {m_wr_req, m_rd_req, bus_oe, busy});
        else n_pass++;
        tick(1);
        n_checks++;
        if ({m_wr_req, m_rd_req} !== 2'b01)
            $display("FAIL arb_second_tie: got %b expected 01", {m_wr_req, m_rd_req});
        else n_pass++;
        tick(12);
        slave_en = 1'b0;
        n_checks++;
        if (gq.size() - gb !== 3 || gq[gb] !== 8'h57 || gq[gb + 1] !== 8'h52 || gq[gb + 2] !== 8'h57)
            $display("FAIL arb_order: got %0d grants expected W,R,W", gq.size() - gb);
        else n_pass++;
        n_checks++;
        if (n_done - b_done !== 3) $display("FAIL arb_done_count: got %0d expected 3", n_done - b_done);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int b_wr, b_done, b_err;
        b_wr = n_wrreq; b_done = n_done; b_err = n_err;
        s_ready = 1'b0;
        wr_len = 8'd3;
        wr_start = 1'b1;
        tick(1);
        wr_start = 1'b0;
        tick(20);
        n_checks++;
        if (n_err - b_err !== 1) $display("FAIL tmo_err_count: got %0d expected 1", n_err - b_err);
        else n_pass++;
        n_checks++;
        if (err_cyc - wr_rise_cyc !== 16)
            $display("FAIL tmo_err_latency: got %0d expected 16", err_cyc - wr_rise_cyc);
        else n_pass++;
        n_checks++;
        if (n_wrreq - b_wr !== 16) $display("FAIL tmo_req_cycles: got %0d expected 16", n_wrreq - b_wr);
        else n_pass++;
        n_checks++;
        if (n_done - b_done !== 0 || busy !== 1'b0)
            $display("FAIL tmo_no_done_idle: got done %0d busy %b expected 0 0", n_done - b_done, busy);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int b_push, b_done, b_err, rb;
        rd_mem[0] = 32'hE0E0_0000;
        rd_mem[1] = 32'hE0E0_0001;
        rk_max = 4'd2;
        clr_models();
        b_push = n_push; b_done = n_done; b_err = n_err; rb = rxq.size();
        slave_en = 1'b1;
        s_ready = 1'b1;
        rd_len = 8'd1;
        rd_start = 1'b1;
        tick(1);
        rd_start = 1'b0;
        tick(1);
        rx_full = 1'b1;
        force_ov = 1'b1;
        #1;
        n_checks++;
        if ({rx_push, m_rd_req, err} !== 3'b000)
            $display("FAIL ovf_no_push: got %b expected 000", {rx_push, m_rd_req, err});
        else n_pass++;
        tick(1);
        rx_full = 1'b0;
        force_ov = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b1) $display("FAIL ovf_err_pulse: got %b expected 1", err);
        else n_pass++;
        tick(6);
        slave_en = 1'b0;
        n_checks++;
        if (n_push - b_push !== 2) $display("FAIL ovf_beats: got %0d expected 2", n_push - b_push);
        else n_pass++;
        n_checks++;
        if (n_err - b_err !== 1 || n_done - b_done !== 1)
            $display("FAIL ovf_err_done: got err %0d done %0d expected 1 1", n_err - b_err, n_done - b_done);
        else n_pass++;
        n_checks++;
        if (rxq.size() < rb + 2 || rxq[rb] !== 32'hE0E0_0000 || rxq[rb + 1] !== 32'hE0E0_0001)
            $display("FAIL ovf_data: got %0d words expected E0E00000,E0E00001", rxq.size() - rb);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int b_done, b_err, b_pop;
        for (int i = 0; i < 8; i++) rd_mem[i] = 32'hF0F0_0000 + 32'(i);
        rk_max = 4'd8;
        clr_models();
        b_done = n_done; b_err = n_err;
        slave_en = 1'b1;
        s_ready = 1'b1;
        rd_len = 8'd7;
        rd_start = 1'b1;
        tick(1);
        rd_start = 1'b0;
        tick(4);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({m_wr_req, m_rd_req, bus_oe, tx_pop, rx_push, bus_ov_out, busy, done, err} !== 9'b0 ||
            {bus_dout, rx_data} !== '0)
            $display("FAIL rst_mid_outputs: got %b expected 000000000",
                     {m_wr_req, m_rd_req, bus_oe, tx_pop, rx_push, bus_ov_out, busy, done, err});
        else n_pass++;
        slave_en = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        n_checks++;
        if (busy !== 1'b0 || n_done - b_done !== 0 || n_err - b_err !== 0)
            $display("FAIL rst_mid_after: got busy %b done %0d err %0d expected 0 0 0",
                     busy, n_done - b_done, n_err - b_err);
        else n_pass++;
        tx_mem[0] = 32'h1234_0000;
        tx_mem[1] = 32'h1234_0001;
        tx_cnt = 4'd2;
        clr_models();
        b_pop = n_pop;
        wr_len = 8'd1;
        wr_start = 1'b1;
        tick(1);
        wr_start = 1'b0;
        tick(8);
        n_checks++;
        if (n_done - b_done !== 1 || n_pop - b_pop !== 2 || n_err - b_err !== 0)
            $display("FAIL rst_mid_rewrite: got done %0d pops %0d err %0d expected 1 2 0",
                     n_done - b_done, n_pop - b_pop, n_err - b_err);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        wr_start = 1'b0; rd_start = 1'b0;
        wr_len = '0; rd_len = '0;
        rx_full = 1'b0; s_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_mem[i] = '0;
            rd_mem[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_timeout();
        test_overflow();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
